// File: rtl/risc_pkg.sv
// Shared types for the instruction-fetch path: address/data widths, fetch FSM
// states and the queue entry that pairs a fetched word with its address.
package risc_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions; flush and rst both empty it.
// Storage is not reset: only pointers and count carry meaning.
module fetch_queue
    import risc_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int PTR_W = $clog2(QDEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(QDEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, runs the one-outstanding imem handshake,
// handles redirects (draining an in-flight read) and feeds decode from a queue.
module inst_fetch_unit #(
    parameter int                      ADDR_W   = risc_pkg::ADDR_W,
    parameter int                      DATA_W   = risc_pkg::DATA_W,
    parameter int                      QDEPTH   = 2,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    input  logic              if_ready
);
    import risc_pkg::*;

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] drain_pc_q, drain_pc_d;
    logic              req_q, req_d;

    logic              ack_ok, flush, push, pop;
    fetch_entry_t      push_data, head;
    logic [CNT_W-1:0]  count, count_next;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        ack_ok     = imem_ack && req_q;
        pop        = (count != '0) && if_ready;
        state_d    = state_q;
        pc_d       = pc_q;
        drain_pc_d = drain_pc_q;
        flush      = 1'b0;
        push       = 1'b0;
        push_data  = '{pc: pc_q, instr: imem_rdata};

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    // An unacked read cannot be cancelled on the bus, so wait it out.
                    if (req_q && !ack_ok) begin
                        state_d    = DRAIN;
                        drain_pc_d = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (ack_ok) begin
                    push = 1'b1;
                    pc_d = pc_q + 1'b1;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    drain_pc_d = redirect_pc;
                end
                if (ack_ok) begin
                    state_d = FETCH;
                    pc_d    = drain_pc_d;
                end
            end
            default: state_d = FETCH;
        endcase

        // Credit check uses next-cycle occupancy so the queue can never overflow.
        count_next = flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
        if (req_q && !ack_ok) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = (count_next < CNT_W'(QDEPTH));
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            drain_pc_q <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            drain_pc_q <= drain_pc_d;
            req_q      <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = (count != '0);
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed vector table, corner-case
// sequences and a randomized run against a queue-based delivery model.
module tb_inst_fetch_unit;

    localparam int QD = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect_valid, imem_ack, if_ready;
    logic [29:0] redirect_pc;
    logic [31:0] imem_rdata;
    logic        imem_req, if_valid;
    logic [29:0] imem_addr, if_pc;
    logic [31:0] if_instr;

    logic        w_ack, w_redirect, w_ready;
    logic [29:0] w_redirect_pc;
    logic [31:0] w_rdata;
    logic        w_req, w_valid;
    logic [29:0] w_addr, w_pc;
    logic [31:0] w_instr;

    inst_fetch_unit #(.QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
    );

    inst_fetch_unit #(.QDEPTH(QD), .RESET_PC(30'h3FFFFFFE)) dut_w (
        .clk(clk), .rst(rst), .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .if_valid(w_valid), .if_pc(w_pc), .if_instr(w_instr), .if_ready(w_ready)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] memfn(input logic [29:0] a);
        return {a[13:0], 2'b01, ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Second instance: always acks in the request cycle, decode always ready.
    bit          w_log = 1'b0;
    logic [29:0] w_addrs[$];
    logic [29:0] w_pcs[$];

    task automatic tick();
        @(negedge clk);
        imem_rdata = memfn(imem_addr);
        if (w_log && w_req === 1'b1) w_addrs.push_back(w_addr);
        if (w_log && w_valid === 1'b1) begin
            w_pcs.push_back(w_pc);
            chk("wrap_instr", w_instr, memfn(w_pc));
        end
        w_ack   = (w_req === 1'b1);
        w_rdata = memfn(w_addr);
    endtask

    task automatic reset_dut();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b0; if_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Ack every request until a request for target shows up (not acked).
    task automatic auto_until(input logic [29:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (imem_req === 1'b1 && imem_addr === target) return;
            imem_ack = (imem_req === 1'b1);
        end
        n_vec++; n_bad++;
        $display("FAIL auto_until: no request for %0h within %0d cycles", target, budget);
    endtask

    typedef struct {
        logic        rst, ack, rdy;
        logic        e_req;
        logic [29:0] e_addr;
        logic        e_valid;
        logic [29:0] e_pc;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic a, input logic er,
                                 input logic [29:0] ea, input logic ev, input logic [29:0] ep);
        vec_t v;
        v.rst = r; v.ack = a; v.rdy = 1'b1;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    // Delivery model: the decode stream is consecutive addresses restarting at each redirect.
    logic [29:0] mq[$];
    bit          drain, prev_hold, first;
    logic [29:0] dtarget, next_fetch, prev_addr;
    int          delivered;

    task automatic model_cycle();
        bit acc;
        chk("m_valid", if_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("m_pc", if_pc, mq[0]);
            chk("m_instr", if_instr, memfn(mq[0]));
        end
        if (prev_hold) begin
            chk("m_hold_req", imem_req, 1);
            chk("m_hold_addr", imem_addr, prev_addr);
        end
        if (imem_req && !drain) chk("m_addr", imem_addr, next_fetch);
        if (!first) chk("m_issue", imem_req, mq.size() < QD);
        first = 1'b0;
        acc = imem_ack && imem_req;
        if (if_ready && mq.size() != 0) begin
            void'(mq.pop_front());
            delivered++;
        end
        if (redirect_valid) begin
            mq.delete();
            if (imem_req && !acc) begin
                drain = 1'b1; dtarget = redirect_pc;
            end else begin
                drain = 1'b0; next_fetch = redirect_pc;
            end
        end else if (acc) begin
            if (drain) begin
                drain = 1'b0; next_fetch = dtarget;
            end else begin
                mq.push_back(imem_addr);
                next_fetch = imem_addr + 30'd1;
            end
        end
        prev_hold = imem_req && !acc;
        prev_addr = imem_addr;
    endtask

    initial begin
        vec_t        tbl[$];
        logic [29:0] wexp[4];
        wexp[0] = 30'h3FFFFFFE; wexp[1] = 30'h3FFFFFFF; wexp[2] = 30'h0; wexp[3] = 30'h1;

        tbl.push_back(mkv(1, 0, 0, 30'd0, 0, 30'd0));
        tbl.push_back(mkv(0, 0, 0, 30'd0, 0, 30'd0));
        tbl.push_back(mkv(0, 0, 1, 30'd0, 0, 30'd0));
        tbl.push_back(mkv(0, 1, 1, 30'd0, 0, 30'd0));
        tbl.push_back(mkv(0, 0, 1, 30'd1, 1, 30'd0));
        tbl.push_back(mkv(0, 1, 1, 30'd1, 0, 30'd0));
        tbl.push_back(mkv(0, 0, 1, 30'd2, 1, 30'd1));
        tbl.push_back(mkv(0, 1, 1, 30'd2, 0, 30'd0));
        tbl.push_back(mkv(0, 0, 1, 30'd3, 1, 30'd2));
        tbl.push_back(mkv(0, 1, 1, 30'd3, 0, 30'd0));
        tbl.push_back(mkv(0, 0, 1, 30'd4, 1, 30'd3));
        tbl.push_back(mkv(0, 0, 1, 30'd4, 0, 30'd0));

        w_redirect = 1'b0; w_redirect_pc = '0; w_ready = 1'b1; w_ack = 1'b0; w_rdata = '0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b0; if_ready = 1'b1;
        imem_rdata = '0;
        tick();

        // Directed table: reset state and 1-per-2-cycle streaming
        foreach (tbl[k]) begin
            tick();
            if (k == 1) w_log = 1'b1;
            chk($sformatf("t_req[%0d]", k), imem_req, tbl[k].e_req);
            if (tbl[k].e_req) chk($sformatf("t_addr[%0d]", k), imem_addr, tbl[k].e_addr);
            if (k == 0) chk("t_rst_addr", imem_addr, 30'd0);
            chk($sformatf("t_valid[%0d]", k), if_valid, tbl[k].e_valid);
            if (tbl[k].e_valid) begin
                chk($sformatf("t_pc[%0d]", k), if_pc, tbl[k].e_pc);
                chk($sformatf("t_instr[%0d]", k), if_instr, memfn(tbl[k].e_pc));
            end
            rst = tbl[k].rst; imem_ack = tbl[k].ack; if_ready = tbl[k].rdy;
        end
        w_log = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_addr[%0d]", i), (i < w_addrs.size()) ? w_addrs[i] : 30'bx, wexp[i]);
            chk($sformatf("wrap_pc[%0d]", i), (i < w_pcs.size()) ? w_pcs[i] : 30'bx, wexp[i]);
        end

        // Decode stalled: only QDEPTH entries fetched, then resume at addr 2
        reset_dut();
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 3) chk("full_req_low", imem_req, 0);
            imem_ack = imem_req;
        end
        chk("full_req", imem_req, 0);
        chk("full_valid", if_valid, 1);
        chk("full_pc0", if_pc, 30'd0);
        imem_ack = 1'b0; if_ready = 1'b1;
        tick();
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 30'd2);
        chk("resume_pc1", if_pc, 30'd1);
        tick();
        chk("resume_empty", if_valid, 0);

        // Redirect while addr 5 outstanding: drain, then refetch 0x100
        reset_dut();
        auto_until(30'd5, 50);
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 30'h100;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drain_req", imem_req, 1);
            chk("drain_addr", imem_addr, 30'd5);
            chk("drain_valid", if_valid, 0);
            redirect_valid = 1'b0;
        end
        imem_ack = 1'b1;
        tick();
        chk("drain_drop", if_valid, 0);
        chk("drain_new_req", imem_req, 1);
        chk("drain_new_addr", imem_addr, 30'h100);
        tick();
        imem_ack = 1'b0;
        chk("drain_first_pc", if_pc, 30'h100);
        chk("drain_first_instr", if_instr, memfn(30'h100));

        // Redirect coincident with ack of addr 7
        reset_dut();
        auto_until(30'd7, 50);
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 30'h40;
        tick();
        redirect_valid = 1'b0;
        chk("rack_empty", if_valid, 0);
        chk("rack_addr", imem_addr, 30'h40);
        tick();
        imem_ack = 1'b0;
        chk("rack_pc", if_pc, 30'h40);
        chk("rack_next_addr", imem_addr, 30'h41);

        // Two redirects while draining: the later target wins
        reset_dut();
        auto_until(30'd3, 50);
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 30'h200;
        tick();
        redirect_pc = 30'h300;
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("latest_addr", imem_addr, 30'h300);
        chk("latest_valid", if_valid, 0);

        // Reset while a request is pending with an entry queued; late ack ignored
        reset_dut();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            imem_ack = imem_req && (i == 1);
        end
        imem_ack = 1'b0; rst = 1'b1;
        tick();
        chk("rst_mid_req", imem_req, 0);
        chk("rst_mid_valid", if_valid, 0);
        rst = 1'b0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_valid", if_valid, 0);
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 30'd0);
        tick();
        chk("late_ack_still_empty", if_valid, 0);

        // Randomized run against the delivery model
        reset_dut();
        mq.delete(); drain = 1'b0; prev_hold = 1'b0; first = 1'b1;
        next_fetch = 30'd0; dtarget = 30'd0; prev_addr = 30'd0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if_ready       = ($urandom_range(0, 3) != 0);
            imem_ack       = imem_req && ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFD : 30'($urandom);
            model_cycle();
        end
        chk("progress", delivered > 300, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
